// File: rtl/keccak_rc_seq.sv
// Sequential Keccak round-constant generator.
// An 8-bit LFSR is unrolled 7 steps per round to produce each constant.
// A runtime round count selects the trailing rounds of Keccak-p[25*LANE_W, nr].
// The leading rounds are skipped in a SEEK phase that emits nothing.
// In RUN, one registered constant is presented per round, advanced by next.
module keccak_rc_seq #(
  parameter  int LANE_W = 64,
  localparam int L      = $clog2(LANE_W),
  localparam int NFULL  = 12 + 2 * L
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [4:0]        nr,
  input  logic              next,
  output logic [LANE_W-1:0] rc,
  output logic              rc_valid,
  output logic [4:0]        round,
  output logic              last,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    RUN  = 2'd2
  } state_e;

  // One round's worth of LFSR output bits, plus the register state 7 steps on.
  typedef struct packed {
    logic [6:0] bits;
    logic [7:0] lfsr;
  } unroll_t;

  localparam logic [4:0] NFULL_5    = 5'(NFULL);
  localparam logic [4:0] LAST_ROUND = 5'(NFULL - 1);
  localparam logic [7:0] LFSR_INIT  = 8'h01;

  // Single LFSR step, polynomial x^8 + x^6 + x^5 + x^4 + 1.
  function automatic logic [7:0] lfsr_step(input logic [7:0] r);
    return {r[6], r[5] ^ r[7], r[4] ^ r[7], r[3] ^ r[7], r[2], r[1], r[0], r[7]};
  endfunction

  // Seven chained steps; bit j is R[0] before step j.
  function automatic unroll_t unroll7(input logic [7:0] r);
    unroll_t    u;
    logic [7:0] s;
    s = r;
    for (int j = 0; j < 7; j++) begin
      u.bits[j] = s[0];
      s         = lfsr_step(s);
    end
    u.lfsr = s;
    return u;
  endfunction

  // Scatter the 7 bits onto positions 2^j-1; truncation drops j > L.
  function automatic logic [LANE_W-1:0] expand(input logic [6:0] b);
    logic [63:0] full;
    full     = '0;
    full[0]  = b[0];
    full[1]  = b[1];
    full[3]  = b[2];
    full[7]  = b[3];
    full[15] = b[4];
    full[31] = b[5];
    full[63] = b[6];
    return full[LANE_W-1:0];
  endfunction

  state_e              state_q, state_d;
  logic [7:0]          lfsr_q, lfsr_d;
  logic [4:0]          round_q, round_d;
  logic [4:0]          seek_q, seek_d;
  logic [LANE_W-1:0]   rc_q, rc_d;
  logic                rc_valid_q, rc_valid_d;
  logic                last_q, last_d;
  logic                busy_q, busy_d;

  unroll_t             cur_u;
  unroll_t             ahead_u;
  unroll_t             init_u;
  logic [4:0]          nr_eff;
  logic [4:0]          seek_init;

  // Next-state logic. In RUN, lfsr_q already holds the state for round_q+1.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves a
    // value unassigned and no latch is inferred.
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    round_d    = round_q;
    seek_d     = seek_q;
    rc_d       = rc_q;
    rc_valid_d = rc_valid_q;
    last_d     = last_q;
    busy_d     = busy_q;

    cur_u     = unroll7(lfsr_q);
    ahead_u   = unroll7(cur_u.lfsr);
    init_u    = unroll7(LFSR_INIT);
    nr_eff    = (nr > NFULL_5) ? NFULL_5 : nr;
    seek_init = NFULL_5 - nr_eff;

    unique case (state_q)
      IDLE: begin
        if (start && (nr != 5'd0)) begin
          busy_d  = 1'b1;
          round_d = 5'd0;
          if (seek_init == 5'd0) begin
            rc_d       = expand(init_u.bits);
            lfsr_d     = init_u.lfsr;
            rc_valid_d = 1'b1;
            last_d     = 1'b0;
            seek_d     = 5'd0;
            state_d    = RUN;
          end else begin
            lfsr_d  = LFSR_INIT;
            seek_d  = seek_init;
            state_d = SEEK;
          end
        end
      end

      SEEK: begin
        round_d = round_q + 5'd1;
        if (seek_q == 5'd1) begin
          // Next round is the first one to emit: load it and pre-advance R.
          rc_d       = expand(ahead_u.bits);
          lfsr_d     = ahead_u.lfsr;
          rc_valid_d = 1'b1;
          last_d     = ((round_q + 5'd1) == LAST_ROUND);
          seek_d     = 5'd0;
          state_d    = RUN;
        end else begin
          lfsr_d = cur_u.lfsr;
          seek_d = seek_q - 5'd1;
        end
      end

      RUN: begin
        if (next) begin
          if (last_q) begin
            rc_d       = '0;
            rc_valid_d = 1'b0;
            round_d    = 5'd0;
            last_d     = 1'b0;
            busy_d     = 1'b0;
            lfsr_d     = LFSR_INIT;
            state_d    = IDLE;
          end else begin
            rc_d    = expand(cur_u.bits);
            lfsr_d  = cur_u.lfsr;
            round_d = round_q + 5'd1;
            last_d  = ((round_q + 5'd1) == LAST_ROUND);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_INIT;
      round_q    <= 5'd0;
      seek_q     <= 5'd0;
      rc_q       <= '0;
      rc_valid_q <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      round_q    <= round_d;
      seek_q     <= seek_d;
      rc_q       <= rc_d;
      rc_valid_q <= rc_valid_d;
      last_q     <= last_d;
      busy_q     <= busy_d;
    end
  end

  assign rc       = rc_q;
  assign rc_valid = rc_valid_q;
  assign round    = round_q;
  assign last     = last_q;
  assign busy     = busy_q;

endmodule
